// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the core-to-memory port arbiter: owner/state enums, the
// buffered request record and default widths.
package mem_port_arbiter_pkg;

  localparam int MEM_ADDR_W     = 32;
  localparam int MEM_DATA_W     = 32;
  localparam int MEM_MASK_W     = MEM_DATA_W / 8;
  localparam int MEM_STARVE_MAX = 4;

  typedef enum logic {ARB_IC, ARB_DC} arb_owner_t;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_MASK_W-1:0] rmask;
    logic [MEM_MASK_W-1:0] wmask;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic arb_owner_t other_port(input arb_owner_t o);
    return (o == ARB_IC) ? ARB_DC : ARB_IC;
  endfunction

endpackage

// File: rtl/mem_req_slot.sv
// One-entry request buffer: holds a single pending core request until its
// response clears it; a capture in the clearing cycle wins.
module mem_req_slot
  import mem_port_arbiter_pkg::*;
#(
  parameter type req_t = mem_req_t
) (
  input  logic clk,
  input  logic rst,
  input  logic capture,
  input  logic clear,
  input  req_t req_in,
  output logic valid,
  output req_t req
);

  logic accept;
  assign accept = capture && (!valid || clear);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      req   <= '0;
    end else if (accept) begin
      valid <= 1'b1;
      req   <= req_in;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  // A second request while the slot is still occupied is dropped.
  a_no_overrun : assert property (@(posedge clk) disable iff (!rst)
    !(capture && valid && !clear))
    else $warning("mem_req_slot: request into occupied slot dropped");

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges instruction (ic_*) and data (dc_*) ports onto one backing port (mem_*).
// Define ARB_ROUND_ROBIN_EN for round-robin; default is dc priority with ic anti-starvation.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int STARVE_MAX = MEM_STARVE_MAX,
  localparam int MASK_W    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic [MASK_W-1:0] ic_rmask,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_resp,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [MASK_W-1:0] dc_rmask,
  input  logic [MASK_W-1:0] dc_wmask,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_resp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MASK_W-1:0] mem_rmask,
  output logic [MASK_W-1:0] mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] rmask;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] wdata;
  } req_t;

  arb_state_t state;
  arb_owner_t owner, winner, sel;
  req_t       ic_req_in, dc_req_in, ic_slot, dc_slot, mem_req;
  logic       ic_req, dc_req, ic_valid, dc_valid;
  logic       done, ic_clear, dc_clear, grant, stray_resp;

  assign ic_req = |ic_rmask;
  assign dc_req = |(dc_rmask | dc_wmask);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ic_req_in       = '0;
    ic_req_in.addr  = ic_addr;
    ic_req_in.rmask = ic_rmask;
    dc_req_in       = '{addr: dc_addr, rmask: dc_rmask, wmask: dc_wmask, wdata: dc_wdata};
  end

  assign done       = (state == ARB_BUSY) && mem_resp;
  assign ic_clear   = done && (owner == ARB_IC);
  assign dc_clear   = done && (owner == ARB_DC);
  assign grant      = (state == ARB_IDLE) && (ic_valid || dc_valid);
  assign stray_resp = (state == ARB_IDLE) && mem_resp;

  mem_req_slot #(.req_t(req_t)) u_ic_slot (
    .clk(clk), .rst(rst), .capture(ic_req), .clear(ic_clear),
    .req_in(ic_req_in), .valid(ic_valid), .req(ic_slot)
  );

  mem_req_slot #(.req_t(req_t)) u_dc_slot (
    .clk(clk), .rst(rst), .capture(dc_req), .clear(dc_clear),
    .req_in(dc_req_in), .valid(dc_valid), .req(dc_slot)
  );

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_t last_grant;

  always_comb begin
    winner = ARB_DC;
    if (ic_valid && dc_valid) winner = other_port(last_grant);
    else if (ic_valid)        winner = ARB_IC;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       last_grant <= ARB_IC;
    else if (grant) last_grant <= winner;
  end
`else
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt;

  // dc wins ties until ic has watched STARVE_MAX dc grants go by.
  always_comb begin
    winner = ARB_DC;
    if (ic_valid && (!dc_valid || starve_cnt >= CNT_W'(STARVE_MAX))) winner = ARB_IC;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          starve_cnt <= '0;
    else if (!ic_valid) starve_cnt <= '0;
    else if (grant)    starve_cnt <= (winner == ARB_IC) ? '0 : starve_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
      owner <= ARB_IC;
    end else begin
      case (state)
        ARB_IDLE: if (grant) begin
          owner <= winner;
          state <= ARB_BUSY;
        end
        ARB_BUSY: if (mem_resp) state <= ARB_IDLE;
      endcase
    end
  end

  // The winner's request is presented in the grant cycle and held from its slot until mem_resp.
  always_comb begin
    mem_req = '0;
    sel     = (state == ARB_BUSY) ? owner : winner;
    if (state == ARB_BUSY || grant) mem_req = (sel == ARB_IC) ? ic_slot : dc_slot;
  end

  assign mem_addr  = mem_req.addr;
  assign mem_rmask = mem_req.rmask;
  assign mem_wmask = mem_req.wmask;
  assign mem_wdata = mem_req.wdata;

  assign ic_resp  = ic_clear;
  assign ic_rdata = ic_clear ? mem_rdata : '0;
  assign dc_resp  = dc_clear;
  assign dc_rdata = dc_clear ? mem_rdata : '0;

  a_no_stray_resp : assert property (@(posedge clk) disable iff (!rst) !stray_resp)
    else $warning("mem_port_arbiter: mem_resp while idle ignored");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ic_addr, ic_rdata, dc_addr, dc_wdata, dc_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  ic_rmask, dc_rmask, dc_wmask, mem_rmask, mem_wmask;
  logic        ic_resp, dc_resp, mem_resp;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .ic_addr(ic_addr), .ic_rmask(ic_rmask), .ic_rdata(ic_rdata), .ic_resp(ic_resp),
    .dc_addr(dc_addr), .dc_rmask(dc_rmask), .dc_wmask(dc_wmask), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_resp(dc_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pending request per port, the transaction in flight, arbitration history.
  bit        m_ic_v, m_dc_v, m_busy, m_own_dc, m_last_dc;
  bit [31:0] m_ic_addr, m_dc_addr, m_dc_wd;
  bit [3:0]  m_ic_rm, m_dc_rm, m_dc_wm;
  int        m_starve, m_lat;

  logic [71:0] s_mem;
  logic [32:0] s_ic, s_dc;
  logic        s_stray;
  int          n_ic_resp = 0, n_dc_resp = 0;

  task automatic m_reset();
    m_ic_v = 0; m_dc_v = 0; m_busy = 0; m_own_dc = 0; m_last_dc = 0;
    m_starve = 0; m_lat = 0;
  endtask

  function automatic bit pick_dc();
`ifdef ARB_ROUND_ROBIN_EN
    if (m_ic_v && m_dc_v) return !m_last_dc;
`else
    if (m_ic_v && m_dc_v) return m_starve < SMAX;
`endif
    return m_dc_v;
  endfunction

  function automatic logic [71:0] exp_mem();
    bit use_dc;
    if (!m_busy && !(m_ic_v || m_dc_v)) return '0;
    use_dc = m_busy ? m_own_dc : pick_dc();
    return use_dc ? {m_dc_addr, m_dc_rm, m_dc_wm, m_dc_wd} : {m_ic_addr, m_ic_rm, 4'h0, 32'h0};
  endfunction

  // One clock: drive inputs, check outputs at negedge, advance the model at posedge.
  task automatic step(input bit ic_go, input bit [31:0] ica, input bit [3:0] icm,
                      input bit dc_go, input bit [31:0] dca, input bit [3:0] dcr,
                      input bit [3:0] dcw, input bit [31:0] dcd,
                      input bit resp, input bit [31:0] rdata);
    bit grant, g_dc, r_ic, r_dc;
    ic_addr  = ica;  ic_rmask = ic_go ? icm : 4'h0;
    dc_addr  = dca;  dc_rmask = dc_go ? dcr : 4'h0;
    dc_wmask = dc_go ? dcw : 4'h0;  dc_wdata = dcd;
    mem_resp = resp; mem_rdata = rdata;
    @(negedge clk);
    r_ic    = m_busy && resp && !m_own_dc;
    r_dc    = m_busy && resp && m_own_dc;
    s_mem   = {mem_addr, mem_rmask, mem_wmask, mem_wdata};
    s_ic    = {ic_resp, ic_rdata};
    s_dc    = {dc_resp, dc_rdata};
    s_stray = dut.stray_resp;
    check("mem_port", s_mem, exp_mem());
    check("ic_return", s_ic, {r_ic, r_ic ? rdata : 32'h0});
    check("dc_return", s_dc, {r_dc, r_dc ? rdata : 32'h0});
    n_ic_resp += int'(s_ic[32]);
    n_dc_resp += int'(s_dc[32]);
    grant = !m_busy && (m_ic_v || m_dc_v);
    g_dc  = pick_dc();
    if (!m_ic_v)    m_starve = 0;
    else if (grant) m_starve = g_dc ? m_starve + 1 : 0;
    if (m_busy && !resp && m_lat > 0) m_lat--;
    if (m_busy && resp) begin
      if (m_own_dc) m_dc_v = 0; else m_ic_v = 0;
      m_busy = 0;
    end else if (grant) begin
      m_busy = 1; m_own_dc = g_dc; m_last_dc = g_dc;
      m_lat  = int'($urandom_range(0, 3));
    end
    if (ic_go && !m_ic_v) begin
      m_ic_v = 1; m_ic_addr = ica; m_ic_rm = icm;
    end
    if (dc_go && !m_dc_v) begin
      m_dc_v = 1; m_dc_addr = dca; m_dc_rm = dcr; m_dc_wm = dcw; m_dc_wd = dcd;
    end
    @(posedge clk); #1;
    ic_rmask = '0; dc_rmask = '0; dc_wmask = '0; mem_resp = 1'b0;
  endtask

  task automatic idle();
    step('0, '0, '0, '0, '0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic respond(input bit [31:0] rdata);
    step('0, '0, '0, '0, '0, '0, '0, '0, 1'b1, rdata);
  endtask

  task automatic drain();
    int guard = 0;
    while ((m_busy || m_ic_v || m_dc_v) && guard < 100) begin
      step('0, '0, '0, '0, '0, '0, '0, '0, m_busy && m_lat == 0, $urandom);
      guard++;
    end
    check("drain_bound", guard >= 100, 1'b0);
  endtask

  initial begin
    int ic0, dc0;
    bit [4:0] order;
    bit out_ic, out_dc, rs, ric, rdc, igo, dgo;
    bit [3:0] dr, dw;

    rst = 1'b0; ic_addr = '0; ic_rmask = '0; dc_addr = '0; dc_rmask = '0;
    dc_wmask = '0; dc_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    m_reset();
    #3;
    check("reset_mem", {mem_addr, mem_rmask, mem_wmask, mem_wdata}, '0);
    check("reset_resp", {ic_resp, ic_rdata, dc_resp, dc_rdata}, '0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // 1: single ic read, response three cycles after the request
    step(1'b1, 32'h0000_1000, 4'hF, '0, '0, '0, '0, '0, 1'b0, '0);
    idle();
    check("t1_issue_addr", s_mem[71:40], 32'h0000_1000);
    check("t1_issue_rmask", s_mem[39:36], 4'hF);
    idle();
    respond(32'hDEAD_BEEF);
    check("t1_ic_data", s_ic, {1'b1, 32'hDEAD_BEEF});
    check("t1_dc_quiet", s_dc[32], 1'b0);
    idle();

    // 2: dc write, request held until mem_resp, one response pulse
    step('0, '0, '0, 1'b1, 32'h0000_2004, 4'h0, 4'h3, 32'h1234_5678, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("t2_write_held", s_mem[71:0], {32'h0000_2004, 4'h0, 4'h3, 32'h1234_5678});
    end
    respond(32'h0BAD_F00D);
    check("t2_dc_resp", s_dc[32], 1'b1);
    idle();
    check("t2_dc_pulse", s_dc[32], 1'b0);

    // 3: simultaneous ic and dc requests
    ic0 = n_ic_resp; dc0 = n_dc_resp;
    step(1'b1, 32'h0000_3000, 4'hF, 1'b1, 32'h0000_4000, 4'hF, 4'h0, '0, 1'b0, '0);
    idle();
`ifdef ARB_ROUND_ROBIN_EN
    check("t3_first", s_mem[71:40], 32'h0000_3000);
`else
    check("t3_first", s_mem[71:40], 32'h0000_4000);
`endif
    respond(32'h1111_1111);
    idle();
`ifdef ARB_ROUND_ROBIN_EN
    check("t3_second", s_mem[71:40], 32'h0000_4000);
`else
    check("t3_second", s_mem[71:40], 32'h0000_3000);
`endif
    respond(32'h2222_2222);
    check("t3_resp_counts", {n_ic_resp - ic0, n_dc_resp - dc0}, {32'd1, 32'd1});
    drain();

`ifndef ARB_ROUND_ROBIN_EN
    // 4: back-to-back dc traffic starves ic until the STARVE_MAX-th dc grant
    step(1'b1, 32'h0000_5000, 4'hF, 1'b1, 32'h0000_6000, 4'hF, 4'h0, '0, 1'b0, '0);
    for (int k = 0; k < 5; k++) begin
      idle();
      order[k] = (s_mem[71:40] != 32'h0000_5000);
      step('0, '0, '0, order[k] && k < 4, 32'h0000_6004 + 32'(k * 4), 4'hF, 4'h0, '0,
           1'b1, 32'(k));
    end
    check("t4_grant_order", order, 5'b01111);
    drain();
`endif

    // 5: reset asserted mid-transaction clears everything immediately
    step(1'b1, 32'h0000_7000, 4'hF, '0, '0, '0, '0, '0, 1'b0, '0);
    idle();
    idle();
    ic0 = n_ic_resp;
    #2 rst = 1'b0; mem_resp = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    check("t5_mem_in_reset", {mem_addr, mem_rmask, mem_wmask, mem_wdata}, '0);
    check("t5_resp_in_reset", {ic_resp, ic_rdata, dc_resp, dc_rdata}, '0);
    @(negedge clk); mem_resp = 1'b0; rst = 1'b1;
    m_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) idle();
    check("t5_no_late_resp", n_ic_resp, ic0);

    // 6: stray mem_resp while idle is ignored and flagged
    respond(32'hCAFE_0001);
    check("t6_no_resp", {s_ic[32], s_dc[32]}, 2'b00);
    check("t6_flagged", s_stray, 1'b1);
    idle();

    // Random traffic, each port respecting one-outstanding-request
    out_ic = 0; out_dc = 0;
    for (int c = 0; c < 600; c++) begin
      rs  = m_busy && m_lat == 0;
      ric = rs && !m_own_dc;
      rdc = rs && m_own_dc;
      igo = (!out_ic || ric) && ($urandom_range(0, 2) == 0);
      dgo = (!out_dc || rdc) && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) begin
        dr = 4'($urandom_range(1, 15)); dw = 4'h0;
      end else begin
        dr = 4'h0; dw = 4'($urandom_range(1, 15));
      end
      step(igo, $urandom, 4'($urandom_range(1, 15)), dgo, $urandom, dr, dw, $urandom,
           rs, $urandom);
      if (ric) out_ic = 0;
      if (igo) out_ic = 1;
      if (rdc) out_dc = 0;
      if (dgo) out_dc = 1;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
